// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: asynchronous-SRAM controller with req/ack front end, big-endian lanes and programmable wait states.
// Defining SRAM_RDATA_REG_EN adds an input register on the read-data path and one extra RD cycle.
module sram_ctrl_param #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int RD_WAIT  = 1,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 1,
  parameter int WR_HOLD  = 1
) (
  input  logic                                 clk50,
  input  logic                                 rst,
  input  logic                                 req_i,
  input  logic                                 we_i,
  input  logic [1:0]                           size_i,
  input  logic                                 sext_i,
  input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]   addr_i,
  input  logic [DATA_W-1:0]                    wdata_i,
  output logic [DATA_W-1:0]                    rdata_o,
  output logic                                 ack_o,
  output logic                                 err_o,
  output logic                                 busy_o,
  output logic [ADDR_W-1:0]                    ramAddr_o,
  output logic                                 CE_n_o,
  output logic                                 OE_n_o,
  output logic                                 WE_n_o,
  output logic [DATA_W/8-1:0]                  be_n_o,
  inout  wire  [DATA_W-1:0]                    data_io
);
  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int AW    = ADDR_W + LB;
  localparam int CNT_W = 8;
`ifdef SRAM_RDATA_REG_EN
  localparam int RD_CYC = RD_WAIT + 1;
`else
  localparam int RD_CYC = RD_WAIT;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_END, S_WR_SU, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_lat_q, rd_lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [NB-1:0]     be_n_q, be_n_d, lane_mask;
  logic              err_q, err_d, ack_q, busy_q;
  logic              ce_n_q, oe_n_q, we_n_q, drive_q;
  logic              misaligned;
  logic [DATA_W-1:0] rd_src;

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    case (sz)
      2'd0:    return {NB{d[7:0]}};
      2'd1:    return {(NB/2){d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane to the top of the word, then take the top byte/half.
  function automatic logic [DATA_W-1:0] extract(input logic [1:0] sz, input logic sx,
                                                input logic [LB-1:0] lane, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] sh;
    logic [7:0]        b;
    logic [15:0]       h;
    sh = d << {lane, 3'b000};
    b  = sh[DATA_W-1 -: 8];
    h  = sh[DATA_W-1 -: 16];
    case (sz)
      2'd0:    return {{(DATA_W-8){sx & b[7]}}, b};
      2'd1:    return {{(DATA_W-16){sx & h[15]}}, h};
      default: return d;
    endcase
  endfunction

`ifdef SRAM_RDATA_REG_EN
  logic [DATA_W-1:0] in_q;
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) in_q <= '0;
    else     in_q <= data_io;
  end
  assign rd_src = in_q;
`else
  assign rd_src = data_io;
`endif

  always_comb begin
    case (size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_i[0];
      2'd2:    misaligned = |addr_i[LB-1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NB; k++) begin
      if (size_q == 2'd2 || k == int'(lane_q) || (size_q == 2'd1 && k == int'(lane_q) + 1))
        lane_mask[NB-1-k] = 1'b1;
    end
  end

  // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    size_d     = size_q;
    sext_d     = sext_q;
    wdata_d    = wdata_q;
    ram_addr_d = ram_addr_q;
    rd_lat_d   = rd_lat_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (req_i) begin
        if (misaligned) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          lane_d     = addr_i[LB-1:0];
          size_d     = size_i;
          sext_d     = sext_i;
          wdata_d    = replicate(size_i, wdata_i);
          ram_addr_d = addr_i[AW-1:LB];
          if (we_i) begin
            state_d = S_WR_SU;
            cnt_d   = CNT_W'(WR_SETUP - 1);
          end else begin
            state_d = S_RD;
            cnt_d   = CNT_W'(RD_CYC);
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          rd_lat_d = rd_src;
          state_d  = S_RD_END;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      S_RD_END: begin
        rdata_d = extract(size_q, sext_q, lane_q, rd_lat_q);
        state_d = S_DONE;
      end
      S_WR_SU: begin
        if (cnt_q == '0) begin
          state_d = S_WR_PULSE;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          cnt_d   = CNT_W'(WR_HOLD - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      S_WR_HOLD: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up with the state they belong to.
  always_comb begin
    be_n_d = '1;
    if (state_d == S_RD)            be_n_d = '0;
    else if (state_d == S_WR_PULSE) be_n_d = ~lane_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      wdata_q    <= '0;
      rd_lat_q   <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      be_n_q     <= '1;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      wdata_q    <= wdata_d;
      rd_lat_q   <= rd_lat_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      be_n_q     <= be_n_d;
      err_q      <= err_d;
      ack_q      <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
      ce_n_q     <= !(state_d inside {S_RD, S_WR_SU, S_WR_PULSE, S_WR_HOLD});
      oe_n_q     <= (state_d != S_RD);
      we_n_q     <= (state_d != S_WR_PULSE);
      drive_q    <= (state_d inside {S_WR_PULSE, S_WR_HOLD});
    end
  end

  assign data_io   = drive_q ? wdata_q : 'z;
  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign ramAddr_o = ram_addr_q;
  assign CE_n_o    = ce_n_q;
  assign OE_n_o    = oe_n_q;
  assign WE_n_o    = we_n_q;
  assign be_n_o    = be_n_q;
endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: table of single accesses on a default instance, plus reset-abort
// and back-to-back load sequences (the latter on an RD_WAIT=3 instance).
module tb_sram_ctrl_param;
`ifdef SRAM_RDATA_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LD_LAT = 1 + 3 + EXTRA;
  localparam int CE_LD  = 2 + EXTRA;
  localparam int LAT3   = 3 + 3 + EXTRA;
  localparam int CE3    = 4 + EXTRA;
  localparam int PER3   = LAT3 + 1;

  logic        clk50, rst;
  logic        req_i, we_i, sext_i;
  logic [1:0]  size_i;
  logic [21:0] addr_i;
  logic [31:0] wdata_i, rdata_o;
  logic        ack_o, err_o, busy_o, ce_n_o, oe_n_o, we_n_o;
  logic [19:0] ram_addr_o;
  logic [3:0]  be_n_o;
  wire  [31:0] data_io;
  logic        tb_force;
  logic [31:0] tb_val, sram_val;

  logic        req3;
  logic [31:0] rdata3;
  logic        ack3, err3, busy3, ce3, oe3, we3;
  logic [19:0] ram3;
  logic [3:0]  be3;
  wire  [31:0] data3;

  int n_err = 0;
  int n_checks = 0;

  sram_ctrl_param dut (
    .clk50(clk50), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i), .sext_i(sext_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o),
    .busy_o(busy_o), .ramAddr_o(ram_addr_o), .CE_n_o(ce_n_o), .OE_n_o(oe_n_o), .WE_n_o(we_n_o),
    .be_n_o(be_n_o), .data_io(data_io)
  );

  sram_ctrl_param #(.RD_WAIT(3)) dut3 (
    .clk50(clk50), .rst(rst), .req_i(req3), .we_i(1'b0), .size_i(2'd2), .sext_i(1'b0),
    .addr_i(22'h0), .wdata_i(32'h0), .rdata_o(rdata3), .ack_o(ack3), .err_o(err3),
    .busy_o(busy3), .ramAddr_o(ram3), .CE_n_o(ce3), .OE_n_o(oe3), .WE_n_o(we3),
    .be_n_o(be3), .data_io(data3)
  );

  // SRAM models: drive the read word while CE_n and OE_n are low; tb_force overrides for the bus-release check.
  assign data_io = tb_force ? tb_val : ((!oe_n_o && !ce_n_o) ? sram_val : 'z);
  assign data3   = (!oe3 && !ce3) ? 32'hCAFEF00D : 'z;

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [21:0] addr;
    logic [31:0] wdata;
    logic [31:0] sram;
    logic        err;
    logic [3:0]  be;
    logic [31:0] bus;
    logic [19:0] ram;
    logic [31:0] rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, output int ack_cyc, output logic err, output int we_low,
                        output int ce_low, output logic [3:0] be_wr, output logic [31:0] bus_wr,
                        output logic [19:0] ram, output logic [31:0] rd);
    ack_cyc = 0; err = 1'b0; we_low = 0; ce_low = 0;
    be_wr = '1; bus_wr = '0; ram = '0; rd = '0;
    @(posedge clk50); #1;
    sram_val = v.sram; we_i = v.we; size_i = v.size; sext_i = v.sext;
    addr_i = v.addr; wdata_i = v.wdata; req_i = 1'b1;
    @(posedge clk50);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk50);
      if (!ce_n_o) begin ce_low++; ram = ram_addr_o; end
      if (!we_n_o) begin we_low++; be_wr = be_n_o; bus_wr = data_io; end
      if (ack_o) begin ack_cyc = c; err = err_o; rd = rdata_o; break; end
    end
    req_i = 1'b0;
  endtask

  initial begin
    vec_t        vt[12];
    int          ack_cyc, we_low, ce_low, exp_ack;
    logic        err, found;
    logic [3:0]  be_wr;
    logic [31:0] bus_wr, rd, hold;
    logic [19:0] ram;
    int          n_ack, n_runs, bad_run, bad_rd, gap, run, first_ack, last_ack;

    //            we    size  sext  addr     wdata          sram           err   be       bus            ram     rd
    vt[0]  = '{1'b1, 2'd2, 1'b0, 22'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'b0000, 32'hDEADBEEF, 20'h4, 32'h0};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 22'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        20'h4, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 22'h11, 32'h0,        32'h12F45678, 1'b0, 4'b1111, 32'h0,        20'h4, 32'hFFFFFFF4};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 22'h11, 32'h0,        32'h12F45678, 1'b0, 4'b1111, 32'h0,        20'h4, 32'h000000F4};
    vt[4]  = '{1'b1, 2'd1, 1'b0, 22'h12, 32'h0000ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD, 20'h4, 32'h0};
    vt[5]  = '{1'b1, 2'd1, 1'b0, 22'h13, 32'h0000ABCD, 32'h0,        1'b1, 4'b1111, 32'h0,        20'h0, 32'h0};
    vt[6]  = '{1'b0, 2'd1, 1'b1, 22'h02, 32'h0,        32'h12F48000, 1'b0, 4'b1111, 32'h0,        20'h0, 32'hFFFF8000};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 22'h00, 32'h0,        32'h80011234, 1'b0, 4'b1111, 32'h0,        20'h0, 32'h00008001};
    vt[8]  = '{1'b1, 2'd0, 1'b0, 22'h23, 32'h1234565A, 32'h0,        1'b0, 4'b1110, 32'h5A5A5A5A, 20'h8, 32'h0};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 22'h02, 32'h0,        32'h11111111, 1'b1, 4'b1111, 32'h0,        20'h0, 32'h0};
    vt[10] = '{1'b0, 2'd3, 1'b0, 22'h00, 32'h0,        32'h11111111, 1'b1, 4'b1111, 32'h0,        20'h0, 32'h0};
    vt[11] = '{1'b0, 2'd0, 1'b1, 22'h10, 32'h0,        32'h7F000000, 1'b0, 4'b1111, 32'h0,        20'h4, 32'h0000007F};

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = '0; sext_i = 1'b0; addr_i = '0;
    wdata_i = '0; tb_force = 1'b0; tb_val = '0; sram_val = '0; req3 = 1'b0;
    #12;
    check("reset_ce_oe_we_n", {29'b0, ce_n_o, oe_n_o, we_n_o}, 32'h7);
    check("reset_be_n", {28'b0, be_n_o}, 32'hF);
    check("reset_ram_addr", {12'b0, ram_addr_o}, 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_ack_err_busy", {29'b0, ack_o, err_o, busy_o}, 32'h0);
    @(negedge clk50); rst = 1'b0;

    hold = 32'h0;
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i], ack_cyc, err, we_low, ce_low, be_wr, bus_wr, ram, rd);
      exp_ack = vt[i].err ? 1 : (vt[i].we ? 4 : LD_LAT);
      check($sformatf("v%0d_ack_cycle", i), ack_cyc, exp_ack);
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vt[i].err});
      check($sformatf("v%0d_ce_low", i), ce_low, vt[i].err ? 0 : (vt[i].we ? 3 : CE_LD));
      check($sformatf("v%0d_we_low", i), we_low, (vt[i].we && !vt[i].err) ? 1 : 0);
      check($sformatf("v%0d_ram_addr", i), {12'b0, ram}, {12'b0, vt[i].ram});
      if (!vt[i].we && !vt[i].err) hold = vt[i].rd;
      check($sformatf("v%0d_rdata", i), rd, hold);
      if (vt[i].we && !vt[i].err) begin
        check($sformatf("v%0d_be_n", i), {28'b0, be_wr}, {28'b0, vt[i].be});
        check($sformatf("v%0d_bus", i), bus_wr, vt[i].bus);
      end
    end

    // Reset during WR_PULSE aborts the store and releases the bus at once.
    @(posedge clk50); #1;
    we_i = 1'b1; size_i = 2'd2; addr_i = 22'h40; wdata_i = 32'hFFFFFFFF; req_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk50);
      if (!we_n_o) found = 1'b1;
    end
    check("rst_reached_wr_pulse", {31'b0, found}, 32'h1);
    rst = 1'b1; req_i = 1'b0; tb_val = 32'h0F0F0F0F; tb_force = 1'b1;
    #1;
    check("rst_we_ce_n", {30'b0, we_n_o, ce_n_o}, 32'h3);
    check("rst_busy_ack", {30'b0, busy_o, ack_o}, 32'h0);
    check("rst_bus_released", data_io, 32'h0F0F0F0F);
    check("rst_rdata_cleared", rdata_o, 32'h0);
    @(negedge clk50); rst = 1'b0; tb_force = 1'b0;
    run_op('{1'b0, 2'd2, 1'b0, 22'h40, 32'h0, 32'h13579BDF, 1'b0, 4'hF, 32'h0, 20'h10, 32'h13579BDF},
           ack_cyc, err, we_low, ce_low, be_wr, bus_wr, ram, rd);
    check("post_rst_ack_cycle", ack_cyc, LD_LAT);
    check("post_rst_rdata", rd, 32'h13579BDF);
    check("post_rst_ram_addr", {12'b0, ram}, 32'h10);

    // Back-to-back loads on the RD_WAIT=3 instance with req held high throughout.
    @(posedge clk50); #1; req3 = 1'b1;
    @(posedge clk50);
    n_ack = 0; n_runs = 0; bad_run = 0; bad_rd = 0; gap = 0; run = 0; first_ack = 0; last_ack = 0;
    for (int c = 1; c <= 3 * PER3 - 1; c++) begin
      @(negedge clk50);
      if (!ce3) run++;
      else if (run != 0) begin
        n_runs++;
        if (run != CE3) bad_run++;
        run = 0;
      end
      if (ack3) begin
        n_ack++;
        if (first_ack == 0) first_ack = c;
        last_ack = c;
        if (rdata3 !== 32'hCAFEF00D) bad_rd++;
      end
      if (!busy3) gap++;
    end
    req3 = 1'b0;
    check("b2b_ack_count", n_ack, 3);
    check("b2b_ce_runs", n_runs, 3);
    check("b2b_ce_run_len_bad", bad_run, 0);
    check("b2b_idle_gaps", gap, 2);
    check("b2b_first_ack", first_ack, LAT3);
    check("b2b_last_ack", last_ack, LAT3 + 2 * PER3);
    check("b2b_rdata_bad", bad_rd, 0);

    repeat (3) @(posedge clk50);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
